// File: rtl/row_col_dec.sv
// Two-stage decoder for the DCO row/column capacitor-array code: recovers the
// binary tuning word {R, C}, flags illegal codes and keeps a saturating error count.
module row_col_dec #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned ROW_W  = 4,
    parameter int unsigned SIZE   = 1 << ROW_W,
    parameter int unsigned ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    input  logic [SIZE-1:0]   r_all,
    input  logic [SIZE-1:0]   row,
    input  logic [SIZE-1:0]   col,
    input  logic              err_clr,
    output logic [WORD_W-1:0] word,
    output logic              out_valid,
    output logic              err,
    output logic              err_sticky,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              changed
);

    localparam int unsigned CNT_W = ROW_W + 1;

    logic            v1;
    logic [SIZE-1:0] r1;
    logic [SIZE-1:0] row1;
    logic [SIZE-1:0] col1;

    logic [CNT_W-1:0]  zeros;
    logic [CNT_W-1:0]  ones;
    logic [SIZE-1:0]   exp_r;
    logic [SIZE-1:0]   exp_c;
    logic              legal;
    logic [WORD_W-1:0] dec_word;

    // Stage 1: capture the code
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1   <= 1'b0;
            r1   <= '0;
            row1 <= '0;
            col1 <= '0;
        end else if (en) begin
            v1 <= in_valid;
            if (in_valid) begin
                r1   <= r_all;
                row1 <= row;
                col1 <= col;
            end
        end
    end

    // Rebuild the only legal r_all/col patterns for the counted R and C, then compare
    always_comb begin
        zeros = '0;
        ones  = '0;
        exp_r = '0;
        exp_c = '0;
        for (int i = 0; i < SIZE; i++) begin
            zeros = zeros + CNT_W'(!r1[i]);
            ones  = ones + CNT_W'(col1[i]);
        end
        for (int i = 0; i < SIZE; i++) begin
            exp_r[i] = (CNT_W'(i) >= zeros);
            if (zeros[0]) begin
                exp_c[i] = ((CNT_W'(i) + ones) >= CNT_W'(SIZE));
            end else begin
                exp_c[i] = (CNT_W'(i) < ones);
            end
        end
        // r1 MSB set bounds zeros to SIZE-1, so the low ROW_W bits are the full row index
        legal = r1[SIZE-1]
              && (r1 == exp_r)
              && (row1 == (SIZE'(1) << zeros[ROW_W-1:0]))
              && (col1 == exp_c)
              && (ones < CNT_W'(SIZE));
        dec_word = WORD_W'({zeros[ROW_W-1:0], ones[ROW_W-1:0]});
    end

    // Stage 2: decoded word and per-decode flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word      <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            changed   <= 1'b0;
        end else if (en) begin
            out_valid <= v1;
            err       <= 1'b0;
            changed   <= 1'b0;
            if (v1) begin
                if (legal) begin
                    word    <= dec_word;
                    changed <= (dec_word != word);
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

    // Error bookkeeping; clear works even while the pipeline is stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else if (en && v1 && !legal) begin
            err_sticky <= 1'b1;
            if (err_cnt != {ERR_W{1'b1}}) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_row_col_dec.sv
// Randomized self-checking bench for row_col_dec against a table-lookup reference
// that searches all 256 legal encodings to classify and decode each code.
module tb_row_col_dec;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic [15:0] r_all;
    logic [15:0] row;
    logic [15:0] col;
    logic        err_clr;
    logic [7:0]  word;
    logic        out_valid;
    logic        err;
    logic        err_sticky;
    logic [7:0]  err_cnt;
    logic        changed;

    int total = 0;
    int bad   = 0;

    row_col_dec dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in_valid   (in_valid),
        .r_all      (r_all),
        .row        (row),
        .col        (col),
        .err_clr    (err_clr),
        .word       (word),
        .out_valid  (out_valid),
        .err        (err),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt),
        .changed    (changed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] r;
        logic [15:0] rw;
        logic [15:0] c;
    } code_t;

    code_t      q[$];
    int         edges;
    logic [7:0] m_word;
    logic       m_ov, m_err, m_chg, m_sticky;
    int         m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Encoding of a word as the row/column encoder would produce it
    function automatic void enc(input int wd, output logic [15:0] r, output logic [15:0] rw,
                                output logic [15:0] c);
        int rr, cc;
        rr = wd / 16;
        cc = wd % 16;
        r  = 16'(32'hFFFF << rr);
        rw = 16'(32'd1 << rr);
        if (rr % 2 == 0) c = 16'((32'd1 << cc) - 32'd1);
        else             c = 16'(32'hFFFF << (16 - cc));
    endfunction

    // A code is legal exactly when some word encodes to it
    function automatic void ref_decode(input logic [15:0] r, input logic [15:0] rw,
                                       input logic [15:0] c, output bit ok, output logic [7:0] w);
        logic [15:0] er, erw, ec;
        ok = 1'b0;
        w  = 8'h00;
        for (int k = 0; k < 256; k++) begin
            enc(k, er, erw, ec);
            if (er == r && erw == rw && ec == c) begin
                ok = 1'b1;
                w  = 8'(k);
            end
        end
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
        chk({tag, ".word"}, 32'(word), 32'(m_word));
        chk({tag, ".err"}, 32'(err), 32'(m_err));
        chk({tag, ".changed"}, 32'(changed), 32'(m_chg));
        chk({tag, ".err_sticky"}, 32'(err_sticky), 32'(m_sticky));
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_cnt));
    endtask

    task automatic step(input string tag, input logic e, input logic iv, input logic [15:0] r,
                        input logic [15:0] rw, input logic [15:0] c, input logic clr);
        code_t p;
        bit ok;
        logic [7:0] w;
        en = e; in_valid = iv; r_all = r; row = rw; col = c; err_clr = clr;
        @(posedge clk);
        if (clr) begin
            m_cnt = 0;
            m_sticky = 1'b0;
        end
        if (e) begin
            edges++;
            m_ov = 1'b0; m_err = 1'b0; m_chg = 1'b0;
            if (q.size() > 0 && q[0].due == edges) begin
                p = q.pop_front();
                ref_decode(p.r, p.rw, p.c, ok, w);
                m_ov = 1'b1;
                if (ok) begin
                    m_chg  = (w != m_word);
                    m_word = w;
                end else begin
                    m_err = 1'b1;
                    if (!clr) begin
                        m_sticky = 1'b1;
                        if (m_cnt < 255) m_cnt++;
                    end
                end
            end
            if (iv) q.push_back('{edges + 1, r, rw, c});
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic step_word(input string tag, input int wd);
        logic [15:0] r, rw, c;
        enc(wd, r, rw, c);
        step(tag, 1'b1, 1'b1, r, rw, c, 1'b0);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0; en = 1'b0; in_valid = 1'b0; err_clr = 1'b0;
        r_all = 16'h0; row = 16'h0; col = 16'h0;
        #1;
        q.delete();
        m_word = 8'h00; m_ov = 1'b0; m_err = 1'b0; m_chg = 1'b0; m_sticky = 1'b0; m_cnt = 0;
        check_all(tag);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [15:0] r, rw, c;
        int sel;
        edges = 0;
        do_reset("reset");

        // Word 0x00
        step("tp0_in", 1'b1, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b0);
        idle("tp0_out");
        chk("tp0_valid", 32'(out_valid), 32'd1);
        chk("tp0_word", 32'(word), 32'h00);

        // Odd row serpentine, then even row
        step("tp1_in", 1'b1, 1'b1, 16'hFFF8, 16'h0008, 16'hF800, 1'b0);
        idle("tp1_out");
        chk("tp1_word", 32'(word), 32'h35);
        chk("tp1_changed", 32'(changed), 32'd1);
        step("tp2_in", 1'b1, 1'b1, 16'hFFFC, 16'h0004, 16'h001F, 1'b0);
        idle("tp2_out");
        chk("tp2_word", 32'(word), 32'h25);
        chk("tp2_changed", 32'(changed), 32'd1);

        // All legal words back-to-back
        for (int k = 0; k < 256; k++) step_word("sweep", k);
        idle("sweep_tail");
        chk("sweep_cnt", 32'(err_cnt), 32'd0);
        chk("sweep_word", 32'(word), 32'hFF);

        // Individual illegal codes
        step("ill_row", 1'b1, 1'b1, 16'hFFFC, 16'h0009, 16'h0003, 1'b0);
        idle("ill_row_out");
        chk("ill_row_err", 32'(err), 32'd1);
        chk("ill_row_word", 32'(word), 32'hFF);
        chk("ill_row_cnt", 32'(err_cnt), 32'd1);
        step("ill_col", 1'b1, 1'b1, 16'hFFF8, 16'h0008, 16'h001F, 1'b0);
        idle("ill_col_out");
        chk("ill_col_err", 32'(err), 32'd1);
        step("ill_rall", 1'b1, 1'b1, 16'hFFF5, 16'h0002, 16'h0000, 1'b0);
        idle("ill_rall_out");
        chk("ill_rall_err", 32'(err), 32'd1);
        step("ill_full", 1'b1, 1'b1, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0);
        idle("ill_full_out");
        chk("ill_full_cnt", 32'(err_cnt), 32'd4);

        // Stall for three cycles mid-stream
        step_word("stall_a", 8'h4A);
        for (int k = 0; k < 3; k++) begin
            enc(8'h91, r, rw, c);
            step("stall", 1'b0, 1'b1, r, rw, c, 1'b0);
        end
        step_word("stall_c", 8'h17);
        chk("stall_a_word", 32'(word), 32'h4A);
        idle("stall_tail");
        chk("stall_c_word", 32'(word), 32'h17);

        // Random legal, corrupted and idle traffic with occasional stalls and clears
        for (int k = 0; k < 400; k++) begin
            enc(int'($urandom_range(0, 255)), r, rw, c);
            sel = int'($urandom_range(0, 5));
            if (sel == 0) r[$urandom_range(0, 15)] ^= 1'b1;
            if (sel == 1) rw[$urandom_range(0, 15)] ^= 1'b1;
            if (sel == 2) c[$urandom_range(0, 15)] ^= 1'b1;
            step("rand", ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0), r, rw, c,
                 ($urandom_range(0, 40) == 0));
        end
        idle("rand_tail");

        // Saturation, then clear colliding with an illegal decode
        for (int k = 0; k < 300; k++) step("sat", 1'b1, 1'b1, 16'hFFF5, 16'h0002, 16'h0000, 1'b0);
        idle("sat_tail");
        chk("sat_cnt", 32'(err_cnt), 32'hFF);
        step("clr_in", 1'b1, 1'b1, 16'hFFF5, 16'h0002, 16'h0000, 1'b0);
        step("clr_hit", 1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
        chk("clr_err", 32'(err), 32'd1);
        chk("clr_cnt", 32'(err_cnt), 32'd0);
        chk("clr_sticky", 32'(err_sticky), 32'd0);

        // Reset with codes in flight
        step_word("rst_a", 8'h66);
        step_word("rst_b", 8'hC3);
        do_reset("rst_mid");
        for (int k = 0; k < 4; k++) idle("post_rst");
        chk("post_rst_word", 32'(word), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
